// File: rtl/fma_sched_pkg.sv
// Shared types and constants for the FMA request scheduler.
package fma_sched_pkg;

  localparam int FMA_W       = 32;
  localparam int ID_W        = 1;
  localparam int FMA_LAT_MIN = 1;
  localparam int FMA_LAT_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } schedStateT;

  // Wide enough to hold FMA_LAT itself, so FMA_LAT-1 always fits.
  function automatic int cntWidth(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/fma_sched_if.sv
// Client-side request/response bundle plus the datapath operand/result lines.
interface fma_sched_if
  import fma_sched_pkg::*;
#(
  parameter int W = FMA_W
);

  logic            req0_valid;
  logic            req0_ready;
  logic [W-1:0]    req0_a;
  logic [W-1:0]    req0_b;
  logic [W-1:0]    req0_c;

  logic            req1_valid;
  logic            req1_ready;
  logic [W-1:0]    req1_a;
  logic [W-1:0]    req1_b;
  logic [W-1:0]    req1_c;

  logic [W-1:0]    fma_a;
  logic [W-1:0]    fma_b;
  logic [W-1:0]    fma_c;
  logic [W-1:0]    fma_d;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [W-1:0]    rsp_data;
  logic [ID_W-1:0] rsp_id;
  logic            busy;

  // Parent side: clients plus the FMA datapath instance.
  modport master (
    output req0_valid, req0_a, req0_b, req0_c,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_c,
    input  req1_ready,
    input  fma_a, fma_b, fma_c,
    output fma_d,
    input  rsp_valid, rsp_data, rsp_id, busy,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_c,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_c,
    output req1_ready,
    output fma_a, fma_b, fma_c,
    input  fma_d,
    output rsp_valid, rsp_data, rsp_id, busy,
    input  rsp_ready
  );

endinterface

// File: rtl/fma_sched_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last time wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       update,
  output logic [1:0] grant,
  output logic       grantIdx
);

  logic lastGrantReg;

  always_comb begin
    grantIdx = 1'b0;
    if (req == 2'b11) begin
      grantIdx = ~lastGrantReg;
    end else if (req[1]) begin
      grantIdx = 1'b1;
    end
    grant = 2'b00;
    if (enable && (req != 2'b00)) begin
      grant = grantIdx ? 2'b10 : 2'b01;
    end
  end

  // Reset to 1 so requester 0 takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastGrantReg <= 1'b1;
    end else if (update) begin
      lastGrantReg <= grantIdx;
    end
  end

endmodule

// File: rtl/fma_sched.sv
// Issues one operand triple at a time to the shared FMA datapath and returns
// the sampled result tagged with the requester that issued it.
module fma_sched
  import fma_sched_pkg::*;
#(
  parameter int FMA_LAT = 2,
  parameter int W       = FMA_W
) (
  input logic        clk,
  input logic        rst,
  fma_sched_if.slave bus
);

  // Out-of-range latencies are clamped rather than building a broken counter.
  localparam int LAT = (FMA_LAT < FMA_LAT_MIN) ? FMA_LAT_MIN :
                       (FMA_LAT > FMA_LAT_MAX) ? FMA_LAT_MAX : FMA_LAT;
  localparam int CW  = cntWidth(LAT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

  schedStateT      stateReg;
  schedStateT      stateNext;
  logic [CW-1:0]   cntReg;
  logic [CW-1:0]   cntNext;

  logic [W-1:0]    fmaAReg;
  logic [W-1:0]    fmaBReg;
  logic [W-1:0]    fmaCReg;
  logic [W-1:0]    rspDataReg;
  logic [ID_W-1:0] rspIdReg;
  logic            rspValidReg;

  logic [1:0]      reqValid;
  logic [1:0]      grant;
  logic            grantIdx;
  logic            arbEnable;
  logic            accept;
  logic            capture;
  logic            rspFire;

  logic [W-1:0]    opA [2];
  logic [W-1:0]    opB [2];
  logic [W-1:0]    opC [2];

  assign reqValid = {bus.req1_valid, bus.req0_valid};
  assign opA[0]   = bus.req0_a;
  assign opB[0]   = bus.req0_b;
  assign opC[0]   = bus.req0_c;
  assign opA[1]   = bus.req1_a;
  assign opB[1]   = bus.req1_b;
  assign opC[1]   = bus.req1_c;

  rr_arb2 uArb (
    .clk      (clk),
    .rst      (rst),
    .req      (reqValid),
    .enable   (arbEnable),
    .update   (accept),
    .grant    (grant),
    .grantIdx (grantIdx)
  );

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    arbEnable = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    rspFire   = 1'b0;
    case (stateReg)
      IDLE: begin
        arbEnable = 1'b1;
        // A grant is only ever raised toward a valid requester, so it is the handshake.
        if (grant != 2'b00) begin
          accept    = 1'b1;
          cntNext   = CNT_LOAD;
          stateNext = EXEC;
        end
      end
      EXEC: begin
        if (cntReg == '0) begin
          capture   = 1'b1;
          stateNext = HOLD;
        end else begin
          cntNext = cntReg - 1'b1;
        end
      end
      HOLD: begin
        if (bus.rsp_ready) begin
          rspFire   = 1'b1;
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= IDLE;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fmaAReg     <= '0;
      fmaBReg     <= '0;
      fmaCReg     <= '0;
      rspDataReg  <= '0;
      rspIdReg    <= '0;
      rspValidReg <= 1'b0;
    end else begin
      if (accept) begin
        fmaAReg  <= opA[grantIdx];
        fmaBReg  <= opB[grantIdx];
        fmaCReg  <= opC[grantIdx];
        rspIdReg <= grantIdx;
      end
      if (capture) begin
        rspDataReg  <= bus.fma_d;
        rspValidReg <= 1'b1;
      end else if (rspFire) begin
        rspValidReg <= 1'b0;
      end
    end
  end

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.fma_a      = fmaAReg;
  assign bus.fma_b      = fmaBReg;
  assign bus.fma_c      = fmaCReg;
  assign bus.rsp_valid  = rspValidReg;
  assign bus.rsp_data   = rspDataReg;
  assign bus.rsp_id     = rspIdReg;
  assign bus.busy       = (stateReg != IDLE);

endmodule

// File: tb/tb_fma_sched.sv
// Directed bench for fma_sched: vector table plus hand-written corner sequences,
// using a lookup-table stand-in for the FMA datapath.
module tb_fma_sched;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fma_sched_if #(.W(32)) b2 ();
  fma_sched_if #(.W(32)) b1 ();

  // Exact products for the triples used; anything else gets a scrambling mix.
  function automatic logic [31:0] fmaModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
    case ({a, b, c})
      {32'h3F800000, 32'h40000000, 32'h40400000}: return 32'h40A00000;
      {32'h40000000, 32'h40400000, 32'hBF800000}: return 32'h40A00000;
      {32'h40000000, 32'h40000000, 32'h00000000}: return 32'h40800000;
      {32'h3FC00000, 32'h40000000, 32'h3F000000}: return 32'h40600000;
      {32'hBF800000, 32'h3F800000, 32'h00000000}: return 32'hBF800000;
      default: return a ^ {b[15:0], b[31:16]} ^ ~c;
    endcase
  endfunction

  assign b2.fma_d = fmaModel(b2.fma_a, b2.fma_b, b2.fma_c);
  assign b1.fma_d = fmaModel(b1.fma_a, b1.fma_b, b1.fma_c);

  fma_sched #(.FMA_LAT(2), .W(32)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
  fma_sched #(.FMA_LAT(1), .W(32)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
  } vecT;

  vecT vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic setReq(input int id, input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c);
    if (id == 0) begin
      b2.req0_valid = v; b2.req0_a = a; b2.req0_b = b; b2.req0_c = c;
    end else begin
      b2.req1_valid = v; b2.req1_a = a; b2.req1_b = b; b2.req1_c = c;
    end
  endtask

  // Waits (bounded) for the requester's ready, then returns 1 time unit after the handshake edge.
  task automatic acceptOn(input int id, output int hsCyc);
    logic got = 1'b0;
    logic rd;
    hsCyc = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      rd = (id == 0) ? b2.req0_ready : b2.req1_ready;
      if (rd) begin
        got = 1'b1;
        break;
      end
    end
    check("accept_seen", 32'(got), 32'd1);
    if (got) begin
      @(posedge clk);
      #1;
      hsCyc = cyc;
    end
  endtask

  task automatic waitRsp(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (b2.rsp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic runOp(input int n);
    int hs;
    int lat;
    setReq(int'(vecs[n].id), 1'b1, vecs[n].a, vecs[n].b, vecs[n].c);
    b2.rsp_ready = 1'b1;
    acceptOn(int'(vecs[n].id), hs);
    setReq(int'(vecs[n].id), 1'b0, vecs[n].a, vecs[n].b, vecs[n].c);
    check($sformatf("vec%0d_fma_a", n), b2.fma_a, vecs[n].a);
    check($sformatf("vec%0d_fma_b", n), b2.fma_b, vecs[n].b);
    check($sformatf("vec%0d_fma_c", n), b2.fma_c, vecs[n].c);
    check($sformatf("vec%0d_busy", n), 32'(b2.busy), 32'd1);
    check($sformatf("vec%0d_readies_exec", n), 32'({b2.req1_ready, b2.req0_ready}), 32'd0);
    waitRsp(lat);
    check($sformatf("vec%0d_latency", n), 32'(lat), 32'd2);
    check($sformatf("vec%0d_rsp_data", n), b2.rsp_data, vecs[n].d);
    check($sformatf("vec%0d_rsp_id", n), 32'(b2.rsp_id), 32'(vecs[n].id));
    @(posedge clk);
    #1;
    check($sformatf("vec%0d_rsp_done", n), 32'({b2.rsp_valid, b2.busy}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    int lat;
    int nAcc;
    int nRsp;
    int accCyc [8];
    int accId [8];
    logic [31:0] rspDat [4];
    logic rspIdv [4];
    logic [31:0] expD;

    vecs[0] = '{id: 1'b0, a: 32'h3F800000, b: 32'h40000000, c: 32'h40400000, d: 32'h40A00000};
    vecs[1] = '{id: 1'b1, a: 32'h40000000, b: 32'h40400000, c: 32'hBF800000, d: 32'h40A00000};
    vecs[2] = '{id: 1'b1, a: 32'h40000000, b: 32'h40000000, c: 32'h00000000, d: 32'h40800000};
    vecs[3] = '{id: 1'b0, a: 32'h3FC00000, b: 32'h40000000, c: 32'h3F000000, d: 32'h40600000};
    vecs[4] = '{id: 1'b1, a: 32'hBF800000, b: 32'h3F800000, c: 32'h00000000, d: 32'hBF800000};

    rst = 1'b1;
    setReq(0, 1'b0, 32'h0, 32'h0, 32'h0);
    setReq(1, 1'b0, 32'h0, 32'h0, 32'h0);
    b2.rsp_ready = 1'b0;
    b1.req0_valid = 1'b0; b1.req0_a = '0; b1.req0_b = '0; b1.req0_c = '0;
    b1.req1_valid = 1'b0; b1.req1_a = '0; b1.req1_b = '0; b1.req1_c = '0;
    b1.rsp_ready = 1'b0;

    #2;
    check("reset_busy", 32'(b2.busy), 32'd0);
    check("reset_rsp_valid", 32'(b2.rsp_valid), 32'd0);
    check("reset_fma_a", b2.fma_a, 32'h0);
    check("reset_rsp_data", b2.rsp_data, 32'h0);
    check("reset_rsp_id", 32'(b2.rsp_id), 32'd0);
    check("reset_readies", 32'({b2.req1_ready, b2.req0_ready}), 32'd0);
    #18;
    rst = 1'b0;

    // Tie: both requesters valid continuously, four operations.
    setReq(0, 1'b1, vecs[0].a, vecs[0].b, vecs[0].c);
    setReq(1, 1'b1, vecs[3].a, vecs[3].b, vecs[3].c);
    b2.rsp_ready = 1'b1;
    nAcc = 0;
    nRsp = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!b2.busy) begin
        check("tie_single_ready", 32'(b2.req0_ready ^ b2.req1_ready), 32'd1);
      end
      if ((b2.req0_ready || b2.req1_ready) && nAcc < 8) begin
        accId[nAcc]  = b2.req1_ready ? 1 : 0;
        accCyc[nAcc] = cyc;
        nAcc++;
      end
      if (b2.rsp_valid && b2.rsp_ready) begin
        rspDat[nRsp] = b2.rsp_data;
        rspIdv[nRsp] = b2.rsp_id;
        nRsp++;
        if (nRsp == 4) break;
      end
    end
    setReq(0, 1'b0, vecs[0].a, vecs[0].b, vecs[0].c);
    setReq(1, 1'b0, vecs[3].a, vecs[3].b, vecs[3].c);
    check("tie_rsp_count", 32'(nRsp), 32'd4);
    if (nRsp == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("tie_grant%0d", i), 32'(accId[i]), 32'(i % 2));
        check($sformatf("tie_rsp_id%0d", i), 32'(rspIdv[i]), 32'(i % 2));
        expD = (i % 2 == 0) ? 32'h40A00000 : 32'h40600000;
        check($sformatf("tie_rsp_data%0d", i), rspDat[i], expD);
        if (i > 0) check($sformatf("tie_interval%0d", i), 32'(accCyc[i] - accCyc[i-1]), 32'd4);
      end
    end
    @(posedge clk);
    #1;

    for (int n = 0; n < 5; n++) runOp(n);

    // Back-pressure: response held for 10 cycles with a competing request waiting.
    b2.rsp_ready = 1'b0;
    setReq(1, 1'b1, vecs[2].a, vecs[2].b, vecs[2].c);
    acceptOn(1, hs);
    setReq(1, 1'b0, vecs[2].a, vecs[2].b, vecs[2].c);
    setReq(0, 1'b1, vecs[0].a, vecs[0].b, vecs[0].c);
    waitRsp(lat);
    check("bp_latency", 32'(lat), 32'd2);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_hold%0d_data", i), b2.rsp_data, 32'h40800000);
      check($sformatf("bp_hold%0d_ctl", i),
            32'({b2.rsp_valid, b2.rsp_id, b2.busy, b2.req1_ready, b2.req0_ready}), 32'b11100);
      @(posedge clk);
      #1;
    end
    b2.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_released", 32'(b2.rsp_valid), 32'd0);
    acceptOn(0, hs);
    setReq(0, 1'b0, vecs[0].a, vecs[0].b, vecs[0].c);
    waitRsp(lat);
    check("bp_next_data", b2.rsp_data, 32'h40A00000);
    @(posedge clk);
    #1;

    // Operand stability: requester scribbles on its operands after the handshake.
    setReq(0, 1'b1, vecs[2].a, vecs[2].b, vecs[2].c);
    acceptOn(0, hs);
    for (int k = 0; k < 10; k++) begin
      setReq(0, 1'b0, $urandom, $urandom, $urandom);
      @(posedge clk);
      #1;
      check($sformatf("stab%0d_fma", k), b2.fma_a ^ {b2.fma_b[15:0], b2.fma_b[31:16]} ^ b2.fma_c,
            vecs[2].a ^ {vecs[2].b[15:0], vecs[2].b[31:16]} ^ vecs[2].c);
      check($sformatf("stab%0d_fma_b", k), b2.fma_b, vecs[2].b);
      if (b2.rsp_valid) begin
        check("stab_rsp_data", b2.rsp_data, 32'h40800000);
        break;
      end
    end
    @(posedge clk);
    #1;

    // Asynchronous reset one cycle after accept, with requester 0 as last grant.
    setReq(0, 1'b1, vecs[3].a, vecs[3].b, vecs[3].c);
    acceptOn(0, hs);
    setReq(0, 1'b0, vecs[3].a, vecs[3].b, vecs[3].c);
    @(posedge clk);
    #3;
    check("rstmid_busy_before", 32'(b2.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid_ctl", 32'({b2.rsp_valid, b2.busy, b2.rsp_id}), 32'd0);
    check("rstmid_fma_a", b2.fma_a, 32'h0);
    check("rstmid_rsp_data", b2.rsp_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("rstmid_no_rsp%0d", k), 32'(b2.rsp_valid), 32'd0);
    end
    setReq(0, 1'b1, vecs[0].a, vecs[0].b, vecs[0].c);
    setReq(1, 1'b1, vecs[1].a, vecs[1].b, vecs[1].c);
    @(negedge clk);
    check("rstmid_tie_winner", 32'({b2.req1_ready, b2.req0_ready}), 32'b01);
    acceptOn(0, hs);
    setReq(0, 1'b0, vecs[0].a, vecs[0].b, vecs[0].c);
    setReq(1, 1'b0, vecs[1].a, vecs[1].b, vecs[1].c);
    waitRsp(lat);
    check("rstmid_tie_rsp_id", 32'(b2.rsp_id), 32'd0);
    check("rstmid_tie_rsp_data", b2.rsp_data, 32'h40A00000);
    @(posedge clk);
    #1;

    // FMA_LAT=1 instance.
    b1.rsp_ready = 1'b1;
    b1.req0_a = 32'h40000000; b1.req0_b = 32'h40400000; b1.req0_c = 32'hBF800000;
    b1.req0_valid = 1'b1;
    lat = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (b1.req0_ready) begin
        lat = 1;
        break;
      end
    end
    check("lat1_accept_seen", 32'(lat), 32'd1);
    @(posedge clk);
    #1;
    b1.req0_valid = 1'b0;
    check("lat1_hs_edge", 32'({b1.busy, b1.rsp_valid}), 32'b10);
    @(posedge clk);
    #1;
    check("lat1_rsp_valid", 32'(b1.rsp_valid), 32'd1);
    check("lat1_rsp_data", b1.rsp_data, 32'h40A00000);
    check("lat1_rsp_id", 32'(b1.rsp_id), 32'd0);
    @(posedge clk);
    #1;
    check("lat1_done", 32'({b1.rsp_valid, b1.busy}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fma_sched.md
# fma_sched

Two-requester scheduler for the shared single-precision FMA datapath (`Top`, D = A×B + C, 32-bit IEEE-754).
- Accepts operand triples from two clients over valid/ready, with round-robin arbitration between them.
- Drives the datapath from registered operands and holds them stable for a fixed multicycle window.
- Captures the result and returns it with the originating requester ID over a valid/ready response port.
- Sits between the client logic and the FMA instance; one operation is in flight at a time.

## Interface
Parameters:
- `FMA_LAT`, default 2: cycles the datapath inputs are held before the result is sampled; legal range 1..15.
- `W`, default 32: operand/result width; fixed at 32 for `Top`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid` in 1, `req0_ready` out 1, `req0_a`/`req0_b`/`req0_c` in W: requester 0 operands.
- `req1_valid` in 1, `req1_ready` out 1, `req1_a`/`req1_b`/`req1_c` in W: requester 1 operands.
- `fma_a`, `fma_b`, `fma_c` out W: registered operands to the datapath.
- `fma_d` in W: datapath result, combinational from `fma_*`.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_data` out W: captured result.
- `rsp_id` out 1: index of the requester that issued the operation.
- `busy` out 1: high in any state other than IDLE.

## Operation
States:
- IDLE
  - Arbiter picks the winner among valid requesters.
  - Only the winner sees ready=1.
  - Ready is combinational from valid and grant state.
  - On handshake: latch the winner's a/b/c into `fma_*`, latch its ID, load counter with FMA_LAT−1, go to EXEC.
- EXEC
  - Both readies are 0; `fma_*` are stable.
  - Counter decrements each cycle.
  - When the counter is 0: register `fma_d` into `rsp_data`, set `rsp_valid`, go to HOLD.
- HOLD
  - `rsp_valid`=1 and `rsp_data`/`rsp_id` are stable.
  - On `rsp_valid`&`rsp_ready`: clear `rsp_valid`, go to IDLE.
  - No request is accepted in the same cycle as the response handshake.

Arbitration:
- `last_grant` register is updated on each accepted request.
- Single valid requester: that requester wins.
- Both valid: the requester ≠ `last_grant` wins.

Requester protocol:
- Once valid is raised it must stay high with stable operands until ready.
- The block samples operands only in the handshake cycle.
- A requester dropping valid before grant is tolerated; nothing is latched for it.

Back-pressure:
- `rsp_ready` held low keeps HOLD indefinitely.
- Both requester readies stay 0 for that whole time.

Arithmetic:
- The block performs no arithmetic on operands.
- Counter width is $clog2(FMA_LAT+1).

## Timing
Reset state (`rst` high, asynchronous):
- State IDLE; `last_grant`=1, so requester 0 wins the first tie.
- `fma_a`/`fma_b`/`fma_c`=0, `rsp_data`=0, `rsp_id`=0, `rsp_valid`=0, `busy`=0, counter=0.
- Readies follow IDLE arbitration, so both are 0 while no valid is asserted.

Latency and throughput:
- Request handshake at edge T. `fma_*` update at T and `busy` rises at T.
- `rsp_valid` rises at edge T+FMA_LAT.
- With `rsp_ready` tied high, the response handshake is at T+FMA_LAT+1.
- Next acceptance is possible no earlier than edge T+FMA_LAT+2.
- Minimum issue interval is FMA_LAT+2 cycles.

Reset mid-operation:
- The in-flight result is discarded and no response is produced.
- `last_grant` returns to 1.

## Structure
- Package `fma_sched_pkg`:
  - state enum (IDLE, EXEC, HOLD);
  - `FMA_W`=32;
  - `ID_W`=1;
  - `FMA_LAT` legal bounds.
- Sub-module `rr_arb2`: 2-way round-robin arbiter.
  - Inputs: req[1:0], enable, update.
  - Outputs: one-hot grant and encoded index.
  - Owns `last_grant`.
- The FMA datapath (`Top`) is instantiated by the parent, not inside this block.

## Test plan
- Single op, FMA_LAT=2:
  - Stimulus: requester 0 sends a=0x3F800000, b=0x40000000, c=0x40400000; `rsp_ready`=1.
  - Required: `rsp_data`=0x40A00000, `rsp_id`=0, `rsp_valid` exactly 2 cycles after the handshake edge.
- Tie:
  - Stimulus: both requesters valid continuously after reset, 4 ops.
  - Required: grants in order 0,1,0,1; each `rsp_id` matches its issuer; issue interval 4 cycles.
- Back-pressure:
  - Stimulus: `rsp_ready`=0 for 10 cycles after `rsp_valid` rises.
  - Required: `rsp_data`/`rsp_id` stable, both readies 0, `busy`=1; response completes on the first cycle `rsp_ready` is 1.
- Operand stability:
  - Stimulus: requester changes a/b/c every cycle after its handshake.
  - Required: `fma_*` unchanged until the next accept; result reflects only the latched values.
- Reset mid-EXEC:
  - Stimulus: assert `rst` asynchronously one cycle after accept.
  - Required: `rsp_valid`=0 and all outputs return to reset values immediately; next tie goes to requester 0.
- FMA_LAT=1 build:
  - Stimulus: a=0x40000000, b=0x40400000, c=0xBF800000.
  - Required: `rsp_data`=0x40A00000 one cycle after accept.
